puf_arb_sampler: RTL and testbench

- Parametrised, clocked successor to the combinational arbiter-PUF array.
- Instantiates N_BITS arbiter chains that share one challenge.
- An FSM fires the chains repeatedly: enable low to relax, enable high to race, then a synchronised capture.
- Each bit is majority-voted over N_SAMPLES races and the voted ID is presented with a per-bit instability mask over a valid/ready handshake. It feeds the key-derivation / fuzzy-extractor path.

---
 rtl/puf_pkg.sv | 27 ++
 rtl/arbiter.sv | 16 +
 rtl/puf_arb_sampler_vote.sv | 57 +++++
 rtl/puf_arb_sampler.sv | 145 ++++++++++++++
 tb/tb_puf_arb_sampler.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// Shared types and constants for the clocked arbiter-PUF sampler.
package puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RELAX,
    S_FIRE,
    S_SAMPLE,
    S_VOTE,
    S_DONE
  } puf_samp_state_t;

  localparam int PUF_N_SAMPLES  = 15;
  localparam int PUF_RELAX_CYC  = 4;
  localparam int PUF_SETTLE_CYC = 4;

  // Ceiling log2, never less than 1 so it is always usable as a vector width.
  function automatic int puf_clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arbiter.sv
// Single arbiter chain stand-in: combinational response to the shared
// challenge, forced low while the chain is relaxing.
module arbiter #(
  parameter int CHAL_W = 32,
  parameter int TAP    = 0
) (
  input  logic              enable_i,
  input  logic [CHAL_W-1:0] challenge_i,
  output logic              resp_o
);

  localparam int IDX = TAP % CHAL_W;

  assign resp_o = enable_i & ((^challenge_i) ^ challenge_i[IDX]);

endmodule

// File: rtl/puf_arb_sampler_vote.sv
// One response bit: 2-flop synchroniser, race counter and the
// majority / instability decision registered on the vote cycle.
module puf_vote_bit
  import puf_pkg::*;
#(
  parameter int N_SAMPLES = PUF_N_SAMPLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic resp_i,
  input  logic clear_i,
  input  logic sample_i,
  input  logic vote_i,
  output logic bit_o,
  output logic unstable_o
);

  localparam int CNT_W = puf_clog2(N_SAMPLES + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(N_SAMPLES / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(N_SAMPLES);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;

  // Resynchronise the asynchronous race outcome every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= resp_i;
      sync2_q <= sync1_q;
    end
  end

  // Count races won; width holds N_SAMPLES so it never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (sample_i) begin
      cnt_q <= cnt_q + CNT_W'(sync2_q);
    end
  end

  // Register the voted bit and instability flag; held until the next vote.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_o      <= 1'b0;
      unstable_o <= 1'b0;
    end else if (vote_i) begin
      bit_o      <= (cnt_q > HALF);
      unstable_o <= (cnt_q != '0) && (cnt_q != FULL);
    end
  end

endmodule

// File: rtl/puf_arb_sampler.sv
// Clocked arbiter-PUF sampler: fires N_BITS chains N_SAMPLES times,
// majority-votes each bit and presents the ID over valid/ready.
// Handshake: valid_o rises when a result is ready and stays high, with
// id_o/unstable_o stable, until an edge where ready_i=1; the transfer
// completes on that edge and valid_o drops.
module puf_arb_sampler
  import puf_pkg::*;
#(
  parameter int N_BITS     = 32,
  parameter int ID_W       = 96,
  parameter int CHAL_W     = 32,
  parameter int N_SAMPLES  = PUF_N_SAMPLES,
  parameter int RELAX_CYC  = PUF_RELAX_CYC,
  parameter int SETTLE_CYC = PUF_SETTLE_CYC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CHAL_W-1:0] challenge_i,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [ID_W-1:0]   id_o,
  output logic [N_BITS-1:0] unstable_o
);

  if (N_SAMPLES < 1 || (N_SAMPLES % 2) == 0 || N_BITS < 1 || N_BITS > ID_W ||
      RELAX_CYC < 1 || SETTLE_CYC < 2) begin : g_bad_params
    $error("puf_arb_sampler: illegal parameter combination");
  end

  localparam int SC_W   = puf_clog2(N_SAMPLES + 1);
  localparam int PH_MAX = (RELAX_CYC > SETTLE_CYC) ? RELAX_CYC : SETTLE_CYC;
  localparam int PH_W   = puf_clog2(PH_MAX);

  puf_samp_state_t   state_q, state_n;
  logic [PH_W-1:0]   phase_q, phase_n;
  logic [SC_W-1:0]   samp_q, samp_n;
  logic [CHAL_W-1:0] chal_q;
  logic              load_chal, clear_cnt, sample_en, vote_en;
  logic              arb_en;
  logic [N_BITS-1:0] arb_resp;
  logic [N_BITS-1:0] race_resp;
  logic [N_BITS-1:0] vote_bits;

  // State, phase/sample counters and the latched challenge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      samp_q  <= '0;
      chal_q  <= '0;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      samp_q  <= samp_n;
      if (load_chal) chal_q <= challenge_i;
    end
  end

  // Next-state and per-state strobes for the relax/fire/sample loop.
  always_comb begin
    state_n   = state_q;
    phase_n   = phase_q;
    samp_n    = samp_q;
    load_chal = 1'b0;
    clear_cnt = 1'b0;
    sample_en = 1'b0;
    vote_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_n   = S_RELAX;
          load_chal = 1'b1;
          clear_cnt = 1'b1;
          phase_n   = '0;
          samp_n    = '0;
        end
      end
      S_RELAX: begin
        if (phase_q == PH_W'(RELAX_CYC - 1)) begin
          state_n = S_FIRE;
          phase_n = '0;
        end else begin
          phase_n = phase_q + PH_W'(1);
        end
      end
      S_FIRE: begin
        if (phase_q == PH_W'(SETTLE_CYC - 1)) begin
          state_n = S_SAMPLE;
          phase_n = '0;
        end else begin
          phase_n = phase_q + PH_W'(1);
        end
      end
      S_SAMPLE: begin
        sample_en = 1'b1;
        phase_n   = '0;
        samp_n    = samp_q + SC_W'(1);
        if (samp_q == SC_W'(N_SAMPLES - 1)) state_n = S_VOTE;
        else                                state_n = S_RELAX;
      end
      S_VOTE: begin
        vote_en = 1'b1;
        state_n = S_DONE;
      end
      S_DONE: begin
        if (ready_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign arb_en    = (state_q == S_FIRE) || (state_q == S_SAMPLE);
  assign busy_o    = (state_q == S_RELAX) || (state_q == S_FIRE) ||
                     (state_q == S_SAMPLE) || (state_q == S_VOTE);
  assign valid_o   = (state_q == S_DONE);
  assign race_resp = arb_resp;
  assign id_o      = ID_W'(vote_bits);

  for (genvar g = 0; g < N_BITS; g++) begin : g_bit
    arbiter #(
      .CHAL_W (CHAL_W),
      .TAP    (g)
    ) u_arb (
      .enable_i    (arb_en),
      .challenge_i (chal_q),
      .resp_o      (arb_resp[g])
    );

    puf_vote_bit #(
      .N_SAMPLES (N_SAMPLES)
    ) u_vote (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .resp_i     (race_resp[g]),
      .clear_i    (clear_cnt),
      .sample_i   (sample_en),
      .vote_i     (vote_en),
      .bit_o      (vote_bits[g]),
      .unstable_o (unstable_o[g])
    );
  end

endmodule

// File: tb/tb_puf_arb_sampler.sv
// Directed bench for puf_arb_sampler: scripted race responses per race,
// hand-computed voted IDs, latency, handshake, reset abort, challenge latch
// and a small-parameter corner instance.
module tb_puf_arb_sampler;
  import puf_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        start_i, ready_i;
  logic [31:0] challenge_i;
  logic        busy_o, valid_o;
  logic [95:0] id_o;
  logic [31:0] unstable_o;

  logic        start_b, ready_b;
  logic [31:0] chal_b;
  logic        busy_b, valid_b;
  logic [7:0]  id_b;
  logic [7:0]  unst_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] script_q [15];
  logic [31:0] script_v;

  puf_arb_sampler dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .challenge_i (challenge_i),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .id_o        (id_o),
    .unstable_o  (unstable_o)
  );

  puf_arb_sampler #(
    .N_BITS     (8),
    .ID_W       (8),
    .CHAL_W     (32),
    .N_SAMPLES  (1),
    .RELAX_CYC  (1),
    .SETTLE_CYC (2)
  ) dut_b (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_b),
    .challenge_i (chal_b),
    .ready_i     (ready_b),
    .busy_o      (busy_b),
    .valid_o     (valid_b),
    .id_o        (id_b),
    .unstable_o  (unst_b)
  );

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_script_const(input logic [31:0] v);
    for (int i = 0; i < 15; i++) script_q[i] = v;
  endtask

  task automatic apply_race(input int k);
    script_v = script_q[k];
    force dut.race_resp = script_v;
  endtask

  // Start a measurement and wait for valid_o; returns cycles from the accepting edge.
  task automatic run_measure(input logic [31:0] chal, input logic [31:0] chal_late, output int lat);
    int cyc;
    apply_race(0);
    start_i     = 1'b1;
    challenge_i = chal;
    @(negedge clk);
    start_i = 1'b0;
    cyc     = 0;
    check_eq("busy_after_accept", busy_o, 1'b1);
    challenge_i = chal_late;
    while (!valid_o && cyc < 400) begin
      if (cyc % 9 == 0 && cyc / 9 < 15) apply_race(cyc / 9);
      if (cyc % 9 == 5) check_eq("latched_challenge", dut.chal_q, chal);
      if (cyc == 135) check_eq("busy_before_done", busy_o, 1'b1);
      @(negedge clk);
      cyc++;
    end
    lat = cyc;
    check_eq("valid_reached", valid_o, 1'b1);
    check_eq("busy_low_at_valid", busy_o, 1'b0);
  endtask

  task automatic take_result();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check_eq("valid_dropped", valid_o, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int cyc;
    logic saw_valid;

    rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b0; challenge_i = '0;
    start_b = 1'b0; ready_b = 1'b0; chal_b = '0;
    script_v = '0;
    force dut.race_resp = script_v;
    force dut_b.race_resp = 8'h3C;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    // Reset state
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_valid", valid_o, 1'b0);
    check_eq("rst_id", id_o, 96'h0);
    check_eq("rst_unstable", unstable_o, 32'h0);
    check_eq("rst_state", dut.state_q, S_IDLE);
    check_eq("rst_valid_b", valid_b, 1'b0);

    // Test 1: stable response
    set_script_const(32'hA5A5_0F0F);
    run_measure(32'hCAFE_0001, 32'hCAFE_0001, lat);
    check_eq("t1_latency", lat, 136);
    check_eq("t1_id", id_o, 96'h0000_0000_0000_0000_A5A5_0F0F);
    check_eq("t1_unstable", unstable_o, 32'h0);

    // Test 3: backpressure with start/challenge toggling
    for (int i = 0; i < 20; i++) begin
      start_i     = i[0];
      challenge_i = 32'h5555_0000 + i;
      @(negedge clk);
      check_eq("bp_valid", valid_o, 1'b1);
      check_eq("bp_id", id_o, 96'h0000_0000_0000_0000_A5A5_0F0F);
      check_eq("bp_busy", busy_o, 1'b0);
    end
    start_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    ready_i = 1'b0;
    check_eq("bp_valid_drop", valid_o, 1'b0);
    check_eq("bp_state_idle", dut.state_q, S_IDLE);
    @(negedge clk);
    check_eq("bp_no_restart", dut.state_q, S_IDLE);
    check_eq("bp_busy_idle", busy_o, 1'b0);
    check_eq("bp_id_kept", id_o, 96'h0000_0000_0000_0000_A5A5_0F0F);

    // Test 2: majority voting on bits 0..2
    for (int k = 0; k < 15; k++) begin
      script_q[k] = 32'hDEAD_BEE8 | 32'h4 |
                    ((k < 8) ? 32'h1 : 32'h0) | ((k < 7) ? 32'h2 : 32'h0);
    end
    run_measure(32'h0000_0002, 32'h0000_0002, lat);
    check_eq("t2_latency", lat, 136);
    check_eq("t2_id", id_o, 96'h0000_0000_0000_0000_DEAD_BEED);
    check_eq("t2_unstable", unstable_o, 32'h0000_0003);
    take_result();

    // Test 5: challenge latching
    set_script_const(32'h1357_9BDF);
    run_measure(32'h1234_5678, 32'hFFFF_FFFF, lat);
    check_eq("t5_latency", lat, 136);
    check_eq("t5_id", id_o, 96'h0000_0000_0000_0000_1357_9BDF);
    take_result();

    // Test 4: reset during the 7th SAMPLE
    set_script_const(32'h0F0F_1111);
    saw_valid = 1'b0;
    apply_race(0);
    start_i     = 1'b1;
    challenge_i = 32'hABCD_0004;
    @(negedge clk);
    start_i = 1'b0;
    cyc     = 0;
    while (cyc < 62) begin
      if (valid_o) saw_valid = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check_eq("t4_in_sample", dut.state_q, S_SAMPLE);
    check_eq("t4_cnt_before", dut.g_bit[0].u_vote.cnt_q, 4'd6);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_eq("t4_state_idle", dut.state_q, S_IDLE);
    check_eq("t4_busy", busy_o, 1'b0);
    check_eq("t4_cnt_cleared", dut.g_bit[0].u_vote.cnt_q, 4'd0);
    check_eq("t4_id_cleared", id_o, 96'h0);
    repeat (20) begin
      @(negedge clk);
      if (valid_o) saw_valid = 1'b1;
    end
    check_eq("t4_no_valid", saw_valid, 1'b0);
    set_script_const(32'h600D_F00D);
    run_measure(32'hABCD_0005, 32'hABCD_0005, lat);
    check_eq("t4_latency", lat, 136);
    check_eq("t4_id", id_o, 96'h0000_0000_0000_0000_600D_F00D);
    check_eq("t4_unstable", unstable_o, 32'h0);
    take_result();

    // Test 6: small-parameter corner instance
    start_b = 1'b1;
    chal_b  = 32'h0000_00AA;
    @(negedge clk);
    start_b = 1'b0;
    cyc     = 0;
    while (!valid_b && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t6_latency", cyc, 5);
    check_eq("t6_id", id_b, 8'h3C);
    check_eq("t6_unstable", unst_b, 8'h00);
    check_eq("t6_busy", busy_b, 1'b0);
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
    check_eq("t6_valid_drop", valid_b, 1'b0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
